// File: rtl/lb_uart_pkg.sv
// Shared widths, frame-size helpers and types for the localbus response UART framer.
package lb_uart_pkg;

  localparam int LBCWIDTH = 8;
  localparam int LBAWIDTH = 24;
  localparam int LBDWIDTH = 32;

  function automatic int lb_fw(input int cw, input int aw, input int dw);
    return cw + aw + dw;
  endfunction

  function automatic int lb_nb(input int fw);
    return fw / 8;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [LBCWIDTH-1:0] ctrl;
    logic [LBAWIDTH-1:0] addr;
    logic [LBDWIDTH-1:0] data;
  } frame_t;

endpackage

// File: rtl/lb_frame_fifo.sv
// Synchronous frame FIFO; dout presents the head entry combinationally from the storage array.
module lb_frame_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr;
  logic             rd;

  // Accept a write when there is room, including the slot freed by a same-cycle read.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == {CW{1'b0}});
    wr      = push && (!full || pop);
    rd      = pop && !empty;
    wptr_d  = wr ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = rd ? (rptr_q + AW'(1)) : rptr_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    dout    = mem_q[rptr_q];
    count   = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Frame storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/lb_resp_uart_framer.sv
// Captures localbus read responses into a frame FIFO and streams each frame MSB-first as bytes to a UART TX.
module lb_resp_uart_framer #(
  parameter int LBCWIDTH = lb_uart_pkg::LBCWIDTH,
  parameter int LBAWIDTH = lb_uart_pkg::LBAWIDTH,
  parameter int LBDWIDTH = lb_uart_pkg::LBDWIDTH,
  parameter int DEPTH    = 4,
  parameter int DROPW    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rready,
  input  logic [LBCWIDTH-1:0] rctrl,
  input  logic [LBAWIDTH-1:0] raddr,
  input  logic [LBDWIDTH-1:0] rdata,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic                clr_overflow,
  output logic                overflow,
  output logic [DROPW-1:0]    drop_cnt,
  output logic                busy
);

  import lb_uart_pkg::state_e;
  import lb_uart_pkg::IDLE;
  import lb_uart_pkg::SEND;
  import lb_uart_pkg::lb_fw;
  import lb_uart_pkg::lb_nb;

  localparam int FW = lb_fw(LBCWIDTH, LBAWIDTH, LBDWIDTH);
  localparam int NB = lb_nb(FW);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [IW-1:0]    IDX_LAST = IW'(NB - 1);
  localparam logic [DROPW-1:0] DROP_MAX = {DROPW{1'b1}};

  if ((FW % 8) != 0) begin : g_bad_fw
    $error("lb_resp_uart_framer: LBCWIDTH+LBAWIDTH+LBDWIDTH must be a multiple of 8");
  end
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lb_resp_uart_framer: DEPTH must be a power of two in 2..16");
  end

  state_e            state_q, state_d;
  logic [FW-1:0]     sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              overflow_q, overflow_d;
  logic [DROPW-1:0]  drop_cnt_q, drop_cnt_d;
  logic              busy_q, busy_d;

  logic              fifo_pop;
  logic              push_ok;
  logic              drop;
  logic [FW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nxt;
  logic              fifo_full;
  logic              fifo_empty;

  lb_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   ({rctrl, raddr, rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Framer FSM: load from the FIFO head, then shift one byte out per accepted transfer.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          idx_d    = {IW{1'b0}};
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            // Chain straight into the next frame so back-to-back frames leave no gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              sh_d     = fifo_dout;
              idx_d    = {IW{1'b0}};
              state_d  = SEND;
            end else begin
              sh_d     = sh_q << 8;
              idx_d    = {IW{1'b0}};
              state_d  = IDLE;
            end
          end else begin
            sh_d  = sh_q << 8;
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Push acceptance, drop accounting and registered output values.
  always_comb begin
    push_ok    = rready && (!fifo_full || fifo_pop);
    drop       = rready && !push_ok;
    count_nxt  = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    tx_valid_d = (state_d == SEND);
    tx_data_d  = tx_valid_d ? sh_d[FW-1 -: 8] : 8'h00;
    busy_d     = (count_nxt != {CW{1'b0}}) || (state_d == SEND);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_cnt_d = DROPW'(1);
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROPW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = {DROPW{1'b0}};
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sh_q       <= {FW{1'b0}};
      idx_q      <= {IW{1'b0}};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROPW{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_lb_resp_uart_framer.sv
// Self-checking bench: a byte/frame-queue reference model checks every cycle, plus directed corner sequences.
module tb_lb_resp_uart_framer;
  import lb_uart_pkg::*;

  localparam int DEPTH   = 4;
  localparam int DROPW   = 3;
  localparam int CNT_MAX = 7;

  logic             clk = 1'b0;
  logic             rstn;
  logic             rready;
  logic [7:0]       rctrl;
  logic [23:0]      raddr;
  logic [31:0]      rdata;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             clr_overflow;
  logic             overflow;
  logic [DROPW-1:0] drop_cnt;
  logic             busy;

  lb_resp_uart_framer #(
    .LBCWIDTH (8), .LBAWIDTH (24), .LBDWIDTH (32), .DEPTH (DEPTH), .DROPW (DROPW)
  ) dut (
    .clk (clk), .rstn (rstn), .rready (rready), .rctrl (rctrl), .raddr (raddr), .rdata (rdata),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready), .clr_overflow (clr_overflow),
    .overflow (overflow), .drop_cnt (drop_cnt), .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: frames waiting in the buffer, and bytes still to send of the frame on the wire.
  logic [63:0] mq[$];
  logic [7:0]  mb[$];
  logic        m_ovf;
  int          m_cnt;

  logic [7:0]  got[$];
  int          got_cyc[$];
  logic [63:0] exp_frames[$];

  typedef struct {
    logic       rr;
    logic       txr;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [7:0] fbyte(input logic [63:0] f, input int k);
    return f[63 - 8*k -: 8];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rr, input logic [63:0] f, input logic txr, input logic clr);
    logic        drp;
    logic [63:0] h;
    logic        ev;
    logic [7:0]  ed;
    logic        eb;
    @(negedge clk);
    rready = rr;
    {rctrl, raddr, rdata} = f;
    tx_ready = txr;
    clr_overflow = clr;
    if (tx_valid && txr) begin
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (mb.size() > 0 && txr) void'(mb.pop_front());
    if (mb.size() == 0 && mq.size() > 0) begin
      h = mq.pop_front();
      for (int k = 0; k < 8; k++) mb.push_back(fbyte(h, k));
    end
    drp = 1'b0;
    if (rr) begin
      if (mq.size() < DEPTH) mq.push_back(f);
      else drp = 1'b1;
    end
    if (drp) begin
      m_ovf = 1'b1;
      m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    ev = (mb.size() > 0);
    ed = ev ? mb[0] : 8'h00;
    eb = (mb.size() > 0) || (mq.size() > 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("tx_valid", 64'(tx_valid), 64'(ev));
    chk("tx_data", 64'(tx_data), 64'(ed));
    chk("busy", 64'(busy), 64'(eb));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
  endtask

  task automatic idle_steps(input int n, input logic txr);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, txr, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    rready = 1'b0;
    tx_ready = 1'b0;
    clr_overflow = 1'b0;
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_tx_data", 64'(tx_data), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    mq.delete(); mb.delete(); m_ovf = 1'b0; m_cnt = 0;
    got.delete(); got_cyc.delete(); exp_frames.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_nbytes"}, 64'(got.size()), 64'(8 * exp_frames.size()));
    for (int i = 0; i < got.size() && i < 8 * exp_frames.size(); i++)
      chk({nm, "_byte"}, 64'(got[i]), 64'(fbyte(exp_frames[i / 8], i % 8)));
  endtask

  function automatic logic [63:0] rnd_frame();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    frame_t      fr1;
    logic [63:0] f;
    logic [7:0]  prev_d;
    logic        prev_stall;

    rstn = 1'b1; rready = 1'b0; tx_ready = 1'b0; clr_overflow = 1'b0;
    rctrl = 8'h00; raddr = 24'h000000; rdata = 32'h00000000;
    fr1 = '{ctrl: 8'h01, addr: 24'h000010, data: 32'hCAFEF00D};

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'hCA, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'hFE, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hF0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h0D, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

    do_reset();

    // Single frame, table-driven with hand-derived expectations
    exp_frames.push_back(fr1);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rr, fr1, tbl[i].txr, 1'b0);
      chk("tbl_valid", 64'(tx_valid), 64'(tbl[i].ev));
      chk("tbl_data", 64'(tx_data), 64'(tbl[i].ed));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].eb));
    end
    check_stream("single");

    // Backpressure: tx_ready 1,0,0,1,...; data must hold while stalled
    do_reset();
    exp_frames.push_back(fr1);
    step(1'b1, fr1, 1'b1, 1'b0);
    prev_stall = 1'b0;
    prev_d = 8'h00;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 64'h0, ((i % 4) == 0) || ((i % 4) == 3), 1'b0);
      if (prev_stall) begin
        chk("bp_hold_valid", 64'(tx_valid), 64'h1);
        chk("bp_hold_data", 64'(tx_data), 64'(prev_d));
      end
      prev_stall = tx_valid && !(((i + 1) % 4) == 0 || ((i + 1) % 4) == 3);
      prev_d = tx_data;
    end
    check_stream("backpressure");

    // Back-to-back frames must stream with no gap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      f = rnd_frame();
      exp_frames.push_back(f);
      step(1'b1, f, 1'b1, 1'b0);
    end
    idle_steps(30, 1'b1);
    check_stream("b2b");
    if (got_cyc.size() == 24) chk("b2b_contiguous", 64'(got_cyc[23] - got_cyc[0]), 64'd23);
    else chk("b2b_count", 64'(got_cyc.size()), 64'd24);

    // Overflow: 6 pushes while stalled -> 1 drop; clear; then all 5 held frames drain
    do_reset();
    for (int i = 0; i < 6; i++) begin
      f = rnd_frame();
      if (i < 5) exp_frames.push_back(f);
      step(1'b1, f, 1'b0, 1'b0);
    end
    chk("ovf_flag", 64'(overflow), 64'h1);
    chk("ovf_cnt", 64'(drop_cnt), 64'h1);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    chk("clr_flag", 64'(overflow), 64'h0);
    chk("clr_cnt", 64'(drop_cnt), 64'h0);
    idle_steps(45, 1'b1);
    check_stream("ovf_drain");
    chk("ovf_idle_busy", 64'(busy), 64'h0);

    // Full FIFO with a push on the same cycle the last byte pops the next frame
    do_reset();
    for (int i = 0; i < 5; i++) begin
      f = rnd_frame();
      exp_frames.push_back(f);
      step(1'b1, f, 1'b0, 1'b0);
    end
    idle_steps(7, 1'b1);
    f = rnd_frame();
    exp_frames.push_back(f);
    step(1'b1, f, 1'b1, 1'b0);
    chk("fullpop_flag", 64'(overflow), 64'h0);
    chk("fullpop_cnt", 64'(drop_cnt), 64'h0);
    idle_steps(50, 1'b1);
    check_stream("fullpop");

    // Clear and drop in the same cycle: the drop wins
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, rnd_frame(), 1'b0, 1'b0);
    chk("pre_clr_cnt", 64'(drop_cnt), 64'h2);
    step(1'b1, rnd_frame(), 1'b0, 1'b1);
    chk("clrdrop_flag", 64'(overflow), 64'h1);
    chk("clrdrop_cnt", 64'(drop_cnt), 64'h1);

    // Saturation of the drop counter
    for (int i = 0; i < 10; i++) step(1'b1, rnd_frame(), 1'b0, 1'b0);
    chk("sat_cnt", 64'(drop_cnt), 64'(CNT_MAX));
    idle_steps(50, 1'b1);

    // Reset mid-frame: output drops at once, nothing resumes afterwards
    do_reset();
    step(1'b1, fr1, 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    chk("mid_nbytes", 64'(got.size()), 64'd3);
    do_reset();
    got.delete();
    idle_steps(12, 1'b1);
    chk("post_rst_bytes", 64'(got.size()), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 800; i++) begin
        step($urandom_range(0, 2) == 0, rnd_frame(), $urandom_range(0, 3) >= p, $urandom_range(0, 63) == 0);
      end
    end
    idle_steps(60, 1'b1);
    chk("rand_final_busy", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
